bus_arbiter: RTL



---
 rtl/bus_arbiter_if.sv | 35 +++
 rtl/bus_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: per-core request/response and shared-RAM bundle for bus_arbiter.
// slave  = arbiter view (takes core requests, drives the RAM port).
// master = environment view (cores plus RAM model).
interface bus_arbiter_if;
  logic [1:0]  req_ren;
  logic [1:0]  req_wen;
  logic [1:0]  req_atomic;
  logic [31:0] req_addr0;
  logic [31:0] req_addr1;
  logic [31:0] req_store0;
  logic [31:0] req_store1;
  logic [31:0] req_load0;
  logic [31:0] req_load1;
  logic [1:0]  req_ack;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic [31:0] ram_load;
  logic        ram_ready;

  modport slave (
    input  req_ren, req_wen, req_atomic, req_addr0, req_addr1, req_store0, req_store1,
    input  ram_load, ram_ready,
    output req_load0, req_load1, req_ack,
    output ram_ren, ram_wen, ram_addr, ram_store
  );

  modport master (
    output req_ren, req_wen, req_atomic, req_addr0, req_addr1, req_store0, req_store1,
    output ram_load, ram_ready,
    input  req_load0, req_load1, req_ack,
    input  ram_ren, ram_wen, ram_addr, ram_store
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two cores sharing one RAM port through an IDLE/BUSY/RESP FSM.
// Round-robin pointer breaks ties; every output is registered.
// Optional LR/SC reservation tracking: define BUS_ARBITER_RESERVATION_EN.
// Without it req_atomic is ignored, SC is a plain write returning 0, LR a plain read.
module bus_arbiter (
  input  logic         CLK,
  input  logic         RST,
  bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        owner_q, owner_d;
  logic        wr_q, wr_d;
  logic        ram_ren_q, ram_ren_d;
  logic        ram_wen_q, ram_wen_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_store_q, ram_store_d;
  logic [31:0] load0_q, load0_d;
  logic [31:0] load1_q, load1_d;
  logic [1:0]  ack_q, ack_d;

  logic [1:0]  act;
  logic        any_req;
  logic        gnt;
  logic        g_wr;
  logic [31:0] g_addr;
  logic [31:0] g_store;
  logic        sc_fail;
  logic [31:0] resp_data;

`ifdef BUS_ARBITER_RESERVATION_EN
  logic             atomic_q, atomic_d;
  logic [1:0]       link_valid_q, link_valid_d;
  logic [1:0][29:0] link_addr_q, link_addr_d;
  logic             g_atomic;
`else
  logic unused_atomic;
  assign unused_atomic = ^bus.req_atomic;
`endif

  // Choose the core to grant; a tie goes to the core named by the pointer.
  always_comb begin
    act     = bus.req_ren | bus.req_wen;
    any_req = |act;
    gnt     = (act == 2'b11) ? ptr_q : act[1];
    g_wr    = bus.req_wen[gnt];
    g_addr  = gnt ? bus.req_addr1 : bus.req_addr0;
    g_store = gnt ? bus.req_store1 : bus.req_store0;
`ifdef BUS_ARBITER_RESERVATION_EN
    g_atomic = bus.req_atomic[gnt];
    sc_fail  = g_wr && g_atomic &&
               !(link_valid_q[gnt] && (link_addr_q[gnt] == g_addr[31:2]));
`else
    sc_fail  = 1'b0;
`endif
  end

  // Next-state and next-output logic for the arbiter FSM.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    ram_ren_d   = ram_ren_q;
    ram_wen_d   = ram_wen_q;
    ram_addr_d  = ram_addr_q;
    ram_store_d = ram_store_q;
    load0_d     = load0_q;
    load1_d     = load1_q;
    ack_d       = 2'b00;
    resp_data   = 32'd0;
`ifdef BUS_ARBITER_RESERVATION_EN
    atomic_d     = atomic_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d     = gnt;
          wr_d        = g_wr;
          ram_addr_d  = g_addr;
          ram_store_d = g_store;
`ifdef BUS_ARBITER_RESERVATION_EN
          atomic_d    = g_atomic;
`endif
          if (sc_fail) begin
            // Failed SC: answer 1 straight away, never touch the RAM.
            state_d    = RESP;
            ack_d[gnt] = 1'b1;
            if (gnt) load1_d = 32'd1;
            else     load0_d = 32'd1;
`ifdef BUS_ARBITER_RESERVATION_EN
            link_valid_d[gnt] = 1'b0;
`endif
          end else begin
            state_d   = BUSY;
            ram_ren_d = !g_wr;
            ram_wen_d = g_wr;
          end
        end
      end
      BUSY: begin
        if (bus.ram_ready) begin
          state_d        = RESP;
          ram_ren_d      = 1'b0;
          ram_wen_d      = 1'b0;
          ack_d[owner_q] = 1'b1;
          resp_data      = wr_q ? 32'd0 : bus.ram_load;
          if (owner_q) load1_d = resp_data;
          else         load0_d = resp_data;
`ifdef BUS_ARBITER_RESERVATION_EN
          // Sets first, clears last, so a clear always wins.
          for (int j = 0; j < 2; j++) begin
            if (!wr_q && atomic_q && (owner_q == 1'(j))) begin
              link_valid_d[j] = 1'b1;
              link_addr_d[j]  = ram_addr_q[31:2];
            end
            if (wr_q && (link_addr_q[j] == ram_addr_q[31:2]))
              link_valid_d[j] = 1'b0;
            if (wr_q && atomic_q && (owner_q == 1'(j)))
              link_valid_d[j] = 1'b0;
          end
`endif
        end
      end
      RESP: begin
        ptr_d   = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register state and outputs; reset abandons any access in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      wr_q        <= 1'b0;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= 32'd0;
      ram_store_q <= 32'd0;
      load0_q     <= 32'd0;
      load1_q     <= 32'd0;
      ack_q       <= 2'b00;
`ifdef BUS_ARBITER_RESERVATION_EN
      atomic_q     <= 1'b0;
      link_valid_q <= 2'b00;
      link_addr_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_store_q <= ram_store_d;
      load0_q     <= load0_d;
      load1_q     <= load1_d;
      ack_q       <= ack_d;
`ifdef BUS_ARBITER_RESERVATION_EN
      atomic_q     <= atomic_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
`endif
    end
  end

  assign bus.req_ack   = ack_q;
  assign bus.req_load0 = load0_q;
  assign bus.req_load1 = load1_q;
  assign bus.ram_ren   = ram_ren_q;
  assign bus.ram_wen   = ram_wen_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_store = ram_store_q;
endmodule
